// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
//   Two-requester command arbiter in front of one AXI4-Lite master port.
//   Each requester posts a single read or write command and holds it until
//   it receives a one-cycle done pulse with read data and response. Requests
//   are served round-robin, and only one AXI transaction is in flight at a
//   time.
//
// Ports
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata   command from requester N (N = 0, 1)
//   reqN_done/rdata/resp          completion pulse, read data and response
//   M_AXI_AW*/W*/B*               AXI4-Lite write channels
//   M_AXI_AR*/R*                  AXI4-Lite read channels
//   M_AXI_ERROR                   sticky flag, set by any non-OKAY response
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transfer; grant a pending request and latch its command
// WR_ADDR | AWVALID/WVALID up; each drops on its own handshake
// WR_RESP | BREADY up, waiting for BVALID
// RD_ADDR | ARVALID up, waiting for ARREADY
// RD_DATA | RREADY up, waiting for RVALID
// DONE    | done pulse to the granted requester, back to IDLE

module axi_lite_cmd_arbiter #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,

   input  logic                            req0_valid,
   input  logic                            req0_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
   output logic                            req0_done,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
   output logic [1:0]                      req0_resp,

   input  logic                            req1_valid,
   input  logic                            req1_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
   output logic                            req1_done,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
   output logic [1:0]                      req1_resp,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,

   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,

   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,

   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY,

   output logic                            M_AXI_ERROR
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t state;
   logic   last_grant;
   logic   sel_q;

   logic                          grant_any;
   logic                          grant_sel;
   logic                          grant_write;
   logic [C_M_AXI_ADDR_WIDTH-1:0] grant_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] grant_wdata;

   logic                          xfer_end;
   logic [1:0]                    xfer_resp;
   logic [C_M_AXI_DATA_WIDTH-1:0] xfer_rdata;
   logic                          aw_clear;
   logic                          w_clear;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_WSTRB  = '1;

   // On a tie the requester not served last wins; a lone requester always wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_grant;
      end else begin
         grant_sel = req1_valid;
      end
      grant_write = grant_sel ? req1_write : req0_write;
      grant_addr  = grant_sel ? req1_addr  : req0_addr;
      grant_wdata = grant_sel ? req1_wdata : req0_wdata;
   end

   // A write channel counts as finished once its VALID has dropped or it
   // handshakes this cycle, so AW and W may complete in either order.
   always_comb begin
      aw_clear   = ~M_AXI_AWVALID | M_AXI_AWREADY;
      w_clear    = ~M_AXI_WVALID  | M_AXI_WREADY;
      xfer_end   = ((state == WR_RESP) && M_AXI_BVALID) ||
                   ((state == RD_DATA) && M_AXI_RVALID);
      xfer_resp  = (state == RD_DATA) ? M_AXI_RRESP : M_AXI_BRESP;
      xfer_rdata = (state == RD_DATA) ? M_AXI_RDATA : '0;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         sel_q         <= 1'b0;
         req0_done     <= 1'b0;
         req0_rdata    <= '0;
         req0_resp     <= 2'b00;
         req1_done     <= 1'b0;
         req1_rdata    <= '0;
         req1_resp     <= 2'b00;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         M_AXI_ERROR   <= 1'b0;
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_any) begin
                  last_grant <= grant_sel;
                  sel_q      <= grant_sel;
                  if (grant_write) begin
                     M_AXI_AWADDR  <= grant_addr;
                     M_AXI_WDATA   <= grant_wdata;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     state         <= WR_ADDR;
                  end else begin
                     M_AXI_ARADDR  <= grant_addr;
                     M_AXI_ARVALID <= 1'b1;
                     state         <= RD_ADDR;
                  end
               end
            end

            WR_ADDR: begin
               if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                  M_AXI_AWVALID <= 1'b0;
               end
               if (M_AXI_WVALID && M_AXI_WREADY) begin
                  M_AXI_WVALID <= 1'b0;
               end
               if (aw_clear && w_clear) begin
                  M_AXI_BREADY <= 1'b1;
                  state        <= WR_RESP;
               end
            end

            WR_RESP: begin
               if (M_AXI_BVALID) begin
                  M_AXI_BREADY <= 1'b0;
               end
            end

            RD_ADDR: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= RD_DATA;
               end
            end

            RD_DATA: begin
               if (M_AXI_RVALID) begin
                  M_AXI_RREADY <= 1'b0;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase

         // Completion is registered on the way into DONE so the pulse, data,
         // response and error flag are all visible during the DONE cycle.
         if (xfer_end) begin
            state <= DONE;
            if (sel_q) begin
               req1_done  <= 1'b1;
               req1_rdata <= xfer_rdata;
               req1_resp  <= xfer_resp;
            end else begin
               req0_done  <= 1'b1;
               req0_rdata <= xfer_rdata;
               req0_resp  <= xfer_resp;
            end
            if (xfer_resp != 2'b00) begin
               M_AXI_ERROR <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// tb_axi_lite_cmd_arbiter
//   Directed bench for axi_lite_cmd_arbiter. A small AXI4-Lite slave model
//   with programmable READY/VALID delays answers the DUT; requester commands
//   are queued per requester and their expected completions are pushed to a
//   per-requester scoreboard when the command is driven.

module tb_axi_lite_cmd_arbiter;

   logic        tb_ACLK = 1'b0;
   logic        tb_ARESETN;

   logic        req0_valid, req0_write, req0_done;
   logic [31:0] req0_addr, req0_wdata, req0_rdata;
   logic [1:0]  req0_resp;
   logic        req1_valid, req1_write, req1_done;
   logic [31:0] req1_addr, req1_wdata, req1_rdata;
   logic [1:0]  req1_resp;

   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY, M_AXI_ERROR;

   always #5 tb_ACLK = ~tb_ACLK;

   axi_lite_cmd_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
      .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
      .req0_resp(req0_resp),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
      .req1_resp(req1_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .M_AXI_ERROR(M_AXI_ERROR)
   );

   int cyc = 0;
   always @(posedge tb_ACLK) cyc <= cyc + 1;

   // ---------------- slave model ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt, out_cnt;
   int          max_out = 0, b_count = 0, viol = 0;
   int          aw_hs_cyc = 0, w_hs_cyc = 0;
   logic        got_aw, got_w, b_pend, r_pend;
   logic [31:0] slv_awaddr = '0, slv_wdata = '0, slv_rdata;
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return 32'hDEAD0001 | (a << 1);
   endfunction

   assign M_AXI_AWREADY = (aw_wait >= aw_delay);
   assign M_AXI_WREADY  = (w_wait  >= w_delay);
   assign M_AXI_ARREADY = (ar_wait >= ar_delay);
   assign M_AXI_BVALID  = b_pend && (b_cnt == 0);
   assign M_AXI_RVALID  = r_pend && (r_cnt == 0);
   assign M_AXI_BRESP   = bresp_cfg;
   assign M_AXI_RRESP   = rresp_cfg;
   assign M_AXI_RDATA   = slv_rdata;
   assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
   assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
   assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
   assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

   always @(posedge tb_ACLK or negedge tb_ARESETN) begin
      if (!tb_ARESETN) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
         got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         out_cnt <= 0; slv_rdata <= '0;
      end else begin
         aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
         w_wait  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_wait + 1  : 0;
         ar_wait <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_wait + 1 : 0;
         if (aw_hs) begin got_aw <= 1'b1; slv_awaddr <= M_AXI_AWADDR; aw_hs_cyc <= cyc; end
         if (w_hs)  begin got_w  <= 1'b1; slv_wdata  <= M_AXI_WDATA;  w_hs_cyc  <= cyc; end
         if (b_pend) begin
            if (b_hs) begin b_pend <= 1'b0; b_count <= b_count + 1; end
            else if (b_cnt > 0) b_cnt <= b_cnt - 1;
         end
         if ((got_aw || aw_hs) && (got_w || w_hs)) begin
            got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b1; b_cnt <= b_delay;
         end
         if (ar_hs) begin
            r_pend <= 1'b1; r_cnt <= r_delay; slv_rdata <= rd_fn(M_AXI_ARADDR);
         end else if (r_pend) begin
            if (r_hs) r_pend <= 1'b0;
            else if (r_cnt > 0) r_cnt <= r_cnt - 1;
         end
         out_cnt <= out_cnt + int'(aw_hs) + int'(ar_hs) - int'(b_hs) - int'(r_hs);
         if (out_cnt + int'(aw_hs) + int'(ar_hs) > max_out)
            max_out <= out_cnt + int'(aw_hs) + int'(ar_hs);
      end
   end

   // VALID must never fall before its handshake.
   always @(posedge tb_ACLK or negedge tb_ARESETN) begin
      if (!tb_ARESETN) begin
         p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      end else begin
         if ((p_awv && !p_awr && !M_AXI_AWVALID) || (p_wv && !p_wr && !M_AXI_WVALID) ||
             (p_arv && !p_arr && !M_AXI_ARVALID))
            viol <= viol + 1;
         p_awv <= M_AXI_AWVALID; p_awr <= M_AXI_AWREADY;
         p_wv  <= M_AXI_WVALID;  p_wr  <= M_AXI_WREADY;
         p_arv <= M_AXI_ARVALID; p_arr <= M_AXI_ARREADY;
      end
   end

   // ---------------- requesters and scoreboard ----------------
   typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
   typedef struct { logic [31:0] rdata; logic [1:0] resp; } exp_t;

   cmd_t cmds0[$], cmds1[$];
   exp_t exp0[$], exp1[$];
   int   done_order[$];
   int   checks = 0, errors = 0;
   int   load_cyc0 = 0, done_cyc0 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk_exp(input cmd_t c);
      exp_t e;
      e.rdata = c.wr ? 32'h0 : rd_fn(c.addr);
      e.resp  = c.wr ? bresp_cfg : rresp_cfg;
      return e;
   endfunction

   // Called once per negedge: retire completions, then present the next command.
   task automatic step_engine();
      exp_t e;
      cmd_t c;
      if (req0_done) begin
         chk("req0_done_expected", 64'(exp0.size() > 0), 64'd1);
         if (exp0.size() > 0) begin
            e = exp0.pop_front();
            chk("req0_rdata", 64'(req0_rdata), 64'(e.rdata));
            chk("req0_resp", 64'(req0_resp), 64'(e.resp));
         end
         done_order.push_back(0);
         done_cyc0 = cyc;
         req0_valid = 1'b0;
      end
      if (req1_done) begin
         chk("req1_done_expected", 64'(exp1.size() > 0), 64'd1);
         if (exp1.size() > 0) begin
            e = exp1.pop_front();
            chk("req1_rdata", 64'(req1_rdata), 64'(e.rdata));
            chk("req1_resp", 64'(req1_resp), 64'(e.resp));
         end
         done_order.push_back(1);
         req1_valid = 1'b0;
      end
      if (!req0_valid && cmds0.size() > 0) begin
         c = cmds0.pop_front();
         req0_write = c.wr; req0_addr = c.addr; req0_wdata = c.wdata; req0_valid = 1'b1;
         exp0.push_back(mk_exp(c));
         load_cyc0 = cyc;
      end
      if (!req1_valid && cmds1.size() > 0) begin
         c = cmds1.pop_front();
         req1_write = c.wr; req1_addr = c.addr; req1_wdata = c.wdata; req1_valid = 1'b1;
         exp1.push_back(mk_exp(c));
      end
   endtask

   function automatic bit busy();
      return req0_valid || req1_valid || cmds0.size() > 0 || cmds1.size() > 0 ||
             exp0.size() > 0 || exp1.size() > 0;
   endfunction

   task automatic run(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge tb_ACLK);
         step_engine();
         n++;
      end while (busy() && n < budget);
      chk(tag, 64'(busy()), 64'd0);
      @(negedge tb_ACLK);
      chk("done_single_cycle", 64'({req0_done, req1_done}), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                               M_AXI_RREADY, req0_done, req1_done, M_AXI_ERROR}), 64'd0);
      chk({tag, "_rdata"}, {req0_rdata, req1_rdata}, 64'd0);
      chk({tag, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 64'd0);
      chk({tag, "_wdata_resp"}, 64'({M_AXI_WDATA, req0_resp, req1_resp}), 64'd0);
   endtask

   initial begin
      int b0;
      bit saw;
      tb_ARESETN = 1'b0;
      req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;

      // reset state
      #3;
      chk_all_zero("reset");
      repeat (3) @(negedge tb_ACLK);
      tb_ARESETN = 1'b1;

      // single write, slave always ready: 4-cycle grant-to-done
      cmds0.push_back('{1'b1, 32'h4, 32'h0101FFFF});
      run("wr_basic_timeout", 40);
      chk("wr_basic_latency", 64'(done_cyc0 - load_cyc0), 64'd3);
      chk("wr_basic_aw_cycle", 64'(aw_hs_cyc - load_cyc0), 64'd1);
      chk("wr_basic_w_cycle", 64'(w_hs_cyc - load_cyc0), 64'd1);
      chk("wr_basic_slv_addr", 64'(slv_awaddr), 64'h4);
      chk("wr_basic_slv_data", 64'(slv_wdata), 64'h0101FFFF);

      // read with ARREADY delay and 5-cycle RVALID delay
      ar_delay = 2; r_delay = 5;
      cmds1.push_back('{1'b0, 32'h8, 32'h0});
      run("rd_delay_timeout", 60);
      chk("rd_delay_fn", 64'(rd_fn(32'h8)), 64'hDEAD0011);

      // both requesters continuously busy: strict alternation
      ar_delay = 0; r_delay = 0;
      done_order.delete();
      cmds0.push_back('{1'b1, 32'h10, 32'h11111111});
      cmds0.push_back('{1'b0, 32'h14, 32'h0});
      cmds0.push_back('{1'b1, 32'h18, 32'h33333333});
      cmds1.push_back('{1'b0, 32'h20, 32'h0});
      cmds1.push_back('{1'b1, 32'h24, 32'h22222222});
      cmds1.push_back('{1'b0, 32'h28, 32'h0});
      run("rr_timeout", 100);
      chk("rr_count", 64'(done_order.size()), 64'd6);
      for (int i = 0; i < done_order.size() && i < 6; i++)
         chk("rr_order", 64'(done_order[i]), 64'(i % 2));

      // W before AW, then AW before W
      w_delay = 0; aw_delay = 3;
      b0 = b_count;
      cmds0.push_back('{1'b1, 32'h100, 32'hA5A5_0001});
      run("w_first_timeout", 40);
      chk("w_first_bphases", 64'(b_count - b0), 64'd1);
      chk("w_first_slv_addr", 64'(slv_awaddr), 64'h100);
      chk("w_first_slv_data", 64'(slv_wdata), 64'hA5A5_0001);
      aw_delay = 0; w_delay = 3;
      b0 = b_count;
      cmds1.push_back('{1'b1, 32'h204, 32'h5A5A_0002});
      run("aw_first_timeout", 40);
      chk("aw_first_bphases", 64'(b_count - b0), 64'd1);
      chk("aw_first_slv_addr", 64'(slv_awaddr), 64'h204);
      chk("aw_first_slv_data", 64'(slv_wdata), 64'h5A5A_0002);
      w_delay = 0;

      // SLVERR response sets the sticky error flag
      chk("error_clear_before", 64'(M_AXI_ERROR), 64'd0);
      bresp_cfg = 2'b10;
      cmds0.push_back('{1'b1, 32'h300, 32'hBAD0BAD0});
      run("slverr_timeout", 40);
      chk("error_set", 64'(M_AXI_ERROR), 64'd1);
      bresp_cfg = 2'b00;
      cmds1.push_back('{1'b0, 32'h304, 32'h0});
      cmds0.push_back('{1'b1, 32'h308, 32'h12345678});
      run("okay_after_err_timeout", 60);
      chk("error_sticky", 64'(M_AXI_ERROR), 64'd1);

      // reset during RD_DATA abandons the read
      r_delay = 20;
      cmds1.push_back('{1'b0, 32'h30, 32'h0});
      for (int i = 0; i < 30 && !M_AXI_RREADY; i++) begin
         @(negedge tb_ACLK);
         step_engine();
      end
      chk("rd_data_reached", 64'(M_AXI_RREADY), 64'd1);
      tb_ARESETN = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      req1_valid = 1'b0;
      exp1.delete();
      saw = 1'b0;
      repeat (3) begin
         @(negedge tb_ACLK);
         if (req0_done || req1_done) saw = 1'b1;
      end
      tb_ARESETN = 1'b1;
      r_delay = 1;
      cmds0.push_back('{1'b0, 32'h40, 32'h0});
      for (int i = 0; i < 40 && busy(); i++) begin
         @(negedge tb_ACLK);
         if (req1_done) saw = 1'b1;
         step_engine();
      end
      chk("no_done_after_abort", 64'(saw), 64'd0);
      chk("post_reset_timeout", 64'(busy()), 64'd0);

      chk("max_outstanding", 64'(max_out), 64'd1);
      chk("valid_drop_violations", 64'(viol), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
